// File: rtl/sio_pad_seq_pkg.sv
// sio_pad_seq_pkg: shared state encoding, pad control word layout and safe word.
`default_nettype none

package sio_pad_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_POWERUP    = 3'd1,
    ST_ACTIVE     = 3'd2,
    ST_HOLD_SETUP = 3'd3,
    ST_HOLD       = 3'd4
  } state_t;

  localparam int CFG_W         = 11;
  localparam int CNT_W         = 8;
  localparam int CFG_OUT       = 0;
  localparam int CFG_OE_N      = 1;
  localparam int CFG_HLD_OVR   = 2;
  localparam int CFG_IBUF_SEL  = 3;
  localparam int CFG_VREG_EN   = 4;
  localparam int CFG_VTRIP_SEL = 5;
  localparam int CFG_SLOW      = 6;
  localparam int CFG_INP_DIS   = 7;
  localparam int CFG_DM        = 8;
  localparam int CFG_DM_W      = 3;

  // Output driver off (OE_N=1), DM=000, everything else cleared.
  localparam logic [CFG_W-1:0] CFG_SAFE = 11'h002;

endpackage

`default_nettype wire

// File: rtl/sio_in_sync.sv
// sio_in_sync: multi-flop synchroniser for the pad input plus edge detection.
`default_nettype none

module sio_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic in,
  output logic in_sync,
  output logic in_rise,
  output logic in_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign in_rise = in_sync & ~prev_q;
  assign in_fall = ~in_sync & prev_q;

endmodule

`default_nettype wire

// File: rtl/sio_pad_seq.sv
// sio_pad_seq: power-up / hold sequencer for a special I/O pad with a
// shadowed configuration word and synchronised input edge detection.
`default_nettype none

module sio_pad_seq
  import sio_pad_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             req_en,
  input  logic             req_hold,
  input  logic             cfg_load,
  input  logic [CFG_W-1:0] cfg,
  output logic [CFG_W-1:0] pad_cfg,
  output logic             enable_h,
  output logic             hld_h_n,
  input  logic             in,
  output logic             in_sync,
  output logic             in_rise,
  output logic             in_fall,
  output logic             ready,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CFG_W-1:0]   shadow, shadow_nxt;
  logic               cfg_err_nxt;
  logic               load_full, load_io;
  logic               raw_rise, raw_fall, edge_en;

  always_comb begin
    state_nxt   = state;
    shadow_nxt  = shadow;
    cfg_err_nxt = 1'b0;
    cnt_nxt     = cnt;

    // Loads are judged by the state the FSM is in now, not where it goes.
    load_full = (state == ST_ACTIVE) || (state == ST_POWERUP);
    load_io   = (state == ST_HOLD) && shadow[CFG_HLD_OVR];
    if (cfg_load) begin
      if (load_full) begin
        shadow_nxt = cfg;
      end else if (load_io) begin
        shadow_nxt[CFG_OE_N] = cfg[CFG_OE_N];
        shadow_nxt[CFG_OUT]  = cfg[CFG_OUT];
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end

    case (state)
      ST_OFF:        if (req_en)      state_nxt = ST_POWERUP;
      ST_POWERUP:    if (cnt == '0)   state_nxt = ST_ACTIVE;
      ST_ACTIVE:     if (req_hold)    state_nxt = ST_HOLD_SETUP;
      ST_HOLD_SETUP: if (cnt == '0)   state_nxt = ST_HOLD;
      ST_HOLD:       if (!req_hold)   state_nxt = ST_ACTIVE;
      default:                        state_nxt = ST_OFF;
    endcase
    if (state != ST_OFF && !req_en) state_nxt = ST_OFF;

    if (state_nxt != state &&
        (state_nxt == ST_POWERUP || state_nxt == ST_HOLD_SETUP)) begin
      cnt_nxt = SETTLE_LOAD;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_OFF;
      cnt      <= '0;
      shadow   <= CFG_SAFE;
      pad_cfg  <= CFG_SAFE;
      enable_h <= 1'b0;
      hld_h_n  <= 1'b0;
      ready    <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shadow   <= shadow_nxt;
      pad_cfg  <= (state_nxt == ST_OFF) ? CFG_SAFE : shadow_nxt;
      // On shutdown the pad word goes safe first; enable drops a cycle later.
      enable_h <= (state_nxt != ST_OFF) || (state != ST_OFF);
      hld_h_n  <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_HOLD_SETUP);
      ready    <= (state_nxt == ST_ACTIVE);
      cfg_err  <= cfg_err_nxt;
    end
  end

  sio_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .in      (in),
    .in_sync (in_sync),
    .in_rise (raw_rise),
    .in_fall (raw_fall)
  );

  assign edge_en = ((state == ST_ACTIVE) || (state == ST_HOLD)) &&
                   !shadow[CFG_INP_DIS] &&
                   (shadow[CFG_DM +: CFG_DM_W] != '0);
  assign in_rise = raw_rise & edge_en;
  assign in_fall = raw_fall & edge_en;

endmodule

`default_nettype wire
